// File: rtl/bcd_bin_seq_pkg.sv
// Shared constants for the sequential BCD-to-binary converter:
// FSM encoding, largest legal BCD digit and the reverse double-dabble correction.
package bcd_bin_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] SUB_THRESH = 4'd8;
    localparam logic [3:0] SUB_AMOUNT = 4'd3;

endpackage

// File: rtl/bcd_bin_seq_sub3.sv
// Reverse double-dabble cell: after a right shift, a digit of 8 or more
// carried a half-ten from the digit above, so 3 is taken back off.
module bcd_bin_seq_sub3
    import bcd_bin_seq_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= SUB_THRESH) ? (digit_i - SUB_AMOUNT) : digit_i;

endmodule

// File: rtl/bcd_bin_seq.sv
// Sequential BCD-to-binary converter with valid/ready on both sides.
// One working register {bcd, bin} is shifted right BIN_W times with per-digit correction.
module bcd_bin_seq
    import bcd_bin_seq_pkg::*;
#(
    parameter int N_DIGITS = 3,
    parameter int BIN_W    = 10,
    parameter int CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_out_q, bin_out_d;
    logic               err_q, err_d;

    logic [BCD_W+BIN_W-1:0] shift_w;
    logic [BCD_W-1:0]       bcd_corr_w;
    logic [N_DIGITS-1:0]    digit_bad_w;
    logic                   any_bad_w;

    assign shift_w = {1'b0, bcd_q, bin_q[BIN_W-1:1]};

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            bcd_bin_seq_sub3 u_sub3 (
                .digit_i (shift_w[BIN_W + 4*gi +: 4]),
                .digit_o (bcd_corr_w[4*gi +: 4])
            );
            assign digit_bad_w[gi] = (bcd_in[4*gi +: 4] > BCD_MAX);
        end
    endgenerate

    assign any_bad_w = |digit_bad_w;

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Illegal digits short-circuit straight to a flagged zero result.
                    if (any_bad_w) begin
                        bin_out_d = '0;
                        err_d     = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        bcd_d   = bcd_in;
                        bin_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                bcd_d = bcd_corr_w;
                bin_d = shift_w[BIN_W-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    bin_out_d = shift_w[BIN_W-1:0];
                    err_d     = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign bin_out   = bin_out_q;
    assign err       = err_q;

endmodule
